sdm_tx_sched: RTL and testbench

//  - Round-robin scheduler sharing one sdm_tx sigma-delta transmitter among NREQ sample sources.
//  - Accepts one 4-bit signed sample per grant over a valid/ready handshake.
//  - Pushes the sample into sdm_tx, then waits until the 16-bit weight frame is fully shifted out before the next grant.
//  - Sits between the sample producers and a single sdm_tx instance, in the sdm_tx clock domain.

---
 rtl/sdm_tx_sched.sv | 165 ++++++++++++++++
 tb/tb_sdm_tx_sched.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdm_tx_sched.sv
// Round-robin scheduler sharing one sdm_tx sigma-delta transmitter among NREQ sources.
// Optional watchdog (counter, tx_clear pulse, sticky err) enabled by defining SDM_SCHED_TMO_EN.

module sdm_tx_sched #(
   parameter int NREQ    = 4,
   parameter int IDW     = 2,
   parameter int TMO_CYC = 65535
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic [NREQ-1:0]   req_valid,
   input  logic [4*NREQ-1:0] req_data,
   output logic [NREQ-1:0]   req_ready,
   input  logic              tx_empty,
   output logic              tx_push,
   output logic              tx_clear,
   output logic [3:0]        tx_wdata,
   output logic [IDW-1:0]    gnt_id,
   output logic              busy,
   output logic              err,
   input  logic              err_clr
);

   localparam int PW = IDW + 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_GRANT,
      S_PUSH,
      S_ACK,
      S_DRAIN
   } state_t;

   state_t          r_state;
   state_t          w_next;
   logic [IDW-1:0]  r_last;
   logic [IDW-1:0]  r_gntId;
   logic [NREQ-1:0] r_ready;
   logic            r_push;
   logic [3:0]      r_wdata;
   logic [IDW-1:0]  w_winner;
   logic [NREQ-1:0] w_gntVec;
   logic [3:0]      w_sample;
   logic [PW-1:0]   w_pos;
   logic            w_found;
   logic            w_grant;
   logic            w_timeout;

   // Search from the slot after the last winner, wrapping, so no valid source starves.
   always_comb begin
      w_found  = 1'b0;
      w_winner = '0;
      w_pos    = '0;
      w_sample = '0;
      w_gntVec = '0;
      for (int k = 1; k <= NREQ; k++) begin
         w_pos = PW'(r_last) + PW'(k);
         if (w_pos >= PW'(NREQ)) begin
            w_pos = w_pos - PW'(NREQ);
         end
         for (int j = 0; j < NREQ; j++) begin
            if ((PW'(j) == w_pos) && req_valid[j] && !w_found) begin
               w_found  = 1'b1;
               w_winner = IDW'(j);
            end
         end
      end
      for (int j = 0; j < NREQ; j++) begin
         if (IDW'(j) == w_winner) begin
            w_sample    = req_data[4*j +: 4];
            w_gntVec[j] = 1'b1;
         end
      end
   end

   assign w_grant = (r_state == S_IDLE) && (|req_valid) && tx_empty;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (w_grant) w_next = S_GRANT;
         S_GRANT: w_next = S_PUSH;
         S_PUSH:  w_next = S_ACK;
         S_ACK:   if (!tx_empty) w_next = S_DRAIN;
         S_DRAIN: if (tx_empty) w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
      if (w_timeout) begin
         w_next = S_IDLE;
      end
   end

   // The grant decision is registered, so ready shows in GRANT and push follows one cycle later.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_ready <= '0;
         r_push  <= 1'b0;
         r_wdata <= '0;
         r_gntId <= '0;
         r_last  <= IDW'(NREQ - 1);
      end else begin
         r_ready <= '0;
         r_push  <= (r_state == S_GRANT);
         if (w_grant && w_found) begin
            r_ready <= w_gntVec;
            r_wdata <= w_sample;
            r_gntId <= w_winner;
            r_last  <= w_winner;
         end
      end
   end

   assign req_ready = r_ready;
   assign tx_push   = r_push;
   assign tx_wdata  = r_wdata;
   assign gnt_id    = r_gntId;
   assign busy      = (r_state != S_IDLE);

`ifdef SDM_SCHED_TMO_EN
   localparam logic [15:0] TMO_LAST = 16'(TMO_CYC - 1);

   logic [15:0] r_tmoCnt;
   logic        r_err;

   // Counter reads 0 in the first ACK cycle, so the timeout lands in wait cycle TMO_CYC.
   assign w_timeout = ((r_state == S_ACK) || (r_state == S_DRAIN)) && (r_tmoCnt == TMO_LAST);

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_tmoCnt <= '0;
         r_err    <= 1'b0;
      end else begin
         if (r_state == S_PUSH) begin
            r_tmoCnt <= '0;
         end else if ((r_state == S_ACK) || (r_state == S_DRAIN)) begin
            r_tmoCnt <= r_tmoCnt + 16'd1;
         end
         if (err_clr) begin
            r_err <= 1'b0;
         end else if (w_timeout) begin
            r_err <= 1'b1;
         end
      end
   end

   assign tx_clear = w_timeout;
   assign err      = r_err;
`else
   logic w_unused;

   assign w_timeout = 1'b0;
   assign tx_clear  = 1'b0;
   assign err       = 1'b0;
   assign w_unused  = err_clr | (TMO_CYC == 0);
`endif

endmodule

// File: tb/tb_sdm_tx_sched.sv
// Self-checking bench for sdm_tx_sched: directed vector table, hand sequences and a
// randomized phase scored against a transaction-level round-robin model with an sdm_tx stand-in.

module tb_sdm_tx_sched;

`ifdef SDM_SCHED_TMO_EN
   localparam int TB_TMO = 16;
`else
   localparam int TB_TMO = 65535;
`endif

   logic        clk = 1'b0;
   logic        rstn = 1'b0;
   logic [3:0]  req_valid = '0;
   logic [15:0] req_data = '0;
   logic [3:0]  req_ready;
   logic        tx_empty = 1'b1;
   logic        tx_push;
   logic        tx_clear;
   logic [3:0]  tx_wdata;
   logic [1:0]  gnt_id;
   logic        busy;
   logic        err;
   logic        err_clr = 1'b0;

   int testCount = 0;
   int failCount = 0;

   // sdm_tx stand-in: loads one cycle after a push, then stays non-empty for a frame
   int  txCnt = 0;
   bit  loadPend = 0;
   bit  forceFull = 0;
   bit  randFrame = 0;

   // Random-phase scoreboard state
   bit         scoreOn = 0;
   bit         pushDue = 0;
   bit         outstanding = 0;
   bit         mLoaded = 0;
   int         mLast = 3;
   int         expId = 0;
   int         stall = 0;
   int         grants = 0;
   int         perSrc[4];
   logic [3:0] expData = '0;

   typedef struct {
      logic [3:0]  valid;
      logic [15:0] data;
      int          expId;
      logic [3:0]  expWdata;
   } vec_t;

   vec_t vecs[10];

   sdm_tx_sched #(.NREQ(4), .IDW(2), .TMO_CYC(TB_TMO)) dut (
      .clk       (clk),
      .rstn      (rstn),
      .req_valid (req_valid),
      .req_data  (req_data),
      .req_ready (req_ready),
      .tx_empty  (tx_empty),
      .tx_push   (tx_push),
      .tx_clear  (tx_clear),
      .tx_wdata  (tx_wdata),
      .gnt_id    (gnt_id),
      .busy      (busy),
      .err       (err),
      .err_clr   (err_clr)
   );

   always #5 clk = ~clk;

   function automatic int rrPick(logic [3:0] v, int last);
      for (int k = 1; k <= 4; k++) begin
         int idx = (last + k) % 4;
         if (v[idx]) return idx;
      end
      return -1;
   endfunction

   task automatic checkOutput(string name, logic [31:0] act, logic [31:0] exp);
      testCount++;
      if (act !== exp) begin
         failCount++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic scoreCycle();
      if (req_ready != 4'b0000) begin
         int id;
         checkOutput("rnd_grant_outside_idle", 32'(outstanding), 32'd0);
         id = rrPick(req_valid, mLast);
         checkOutput("rnd_ready", 32'(req_ready), (id < 0) ? 32'd0 : (32'd1 << id));
         expId       = id;
         expData     = req_data[4*id +: 4];
         mLast       = id;
         pushDue     = 1;
         outstanding = 1;
         mLoaded     = 0;
         stall       = 0;
         grants++;
         perSrc[id]++;
      end else if (!outstanding && (req_valid != 4'b0000)) begin
         stall++;
         if (stall > 4) begin
            checkOutput("rnd_grant_latency", 32'(req_ready), 32'd1 << rrPick(req_valid, mLast));
            stall = 0;
         end
      end
      if (pushDue && (req_ready == 4'b0000)) begin
         checkOutput("rnd_push", 32'(tx_push), 32'd1);
         checkOutput("rnd_wdata", 32'(tx_wdata), 32'(expData));
         checkOutput("rnd_gnt_id", 32'(gnt_id), 32'(expId));
         pushDue = 0;
         req_valid[expId] = ($urandom_range(0, 3) != 0);
         req_data[4*expId +: 4] = 4'($urandom);
      end else if (!pushDue) begin
         checkOutput("rnd_no_push", 32'(tx_push), 32'd0);
      end
      if (outstanding && mLoaded && (txCnt == 0)) outstanding = 0;
      for (int i = 0; i < 4; i++) begin
         if (!req_valid[i] && ($urandom_range(0, 3) == 0)) begin
            req_valid[i] = 1'b1;
            req_data[4*i +: 4] = 4'($urandom);
         end
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      if (txCnt > 0) txCnt--;
      if (loadPend) begin
         txCnt    = randFrame ? int'($urandom_range(2, 18)) : 16;
         loadPend = 0;
         mLoaded  = 1;
      end
      if (tx_push) loadPend = 1;
      if (scoreOn) scoreCycle();
      tx_empty = (txCnt == 0) && !forceFull;
   endtask

   task automatic applyReset();
      rstn      = 1'b0;
      req_valid = '0;
      err_clr   = 1'b0;
      forceFull = 0;
      txCnt     = 0;
      loadPend  = 0;
      tx_empty  = 1'b1;
      #1;
      checkOutput("rst_req_ready", 32'(req_ready), 32'd0);
      checkOutput("rst_tx_push", 32'(tx_push), 32'd0);
      checkOutput("rst_tx_clear", 32'(tx_clear), 32'd0);
      checkOutput("rst_tx_wdata", 32'(tx_wdata), 32'd0);
      checkOutput("rst_gnt_id", 32'(gnt_id), 32'd0);
      checkOutput("rst_busy", 32'(busy), 32'd0);
      checkOutput("rst_err", 32'(err), 32'd0);
      repeat (2) @(posedge clk);
      #1;
      rstn = 1'b1;
   endtask

   task automatic applyStimulus(logic [3:0] v, logic [15:0] d);
      req_valid = v;
      req_data  = d;
   endtask

   task automatic waitReady();
      for (int c = 0; c < 40; c++) begin
         tick();
         if (req_ready != 4'b0000) break;
      end
   endtask

   task automatic waitIdle(string name);
      for (int c = 0; c < 60; c++) begin
         if (!busy) break;
         tick();
      end
      checkOutput({name, "_idle"}, 32'(busy), 32'd0);
   endtask

   task automatic runGrant(string name, logic [3:0] v, logic [15:0] d, int id,
                           logic [3:0] wdata, bit holdValid);
      applyStimulus(v, d);
      waitReady();
      checkOutput({name, "_ready"}, 32'(req_ready), 32'd1 << id);
      tick();
      checkOutput({name, "_ready_1cyc"}, 32'(req_ready), 32'd0);
      checkOutput({name, "_push"}, 32'(tx_push), 32'd1);
      checkOutput({name, "_wdata"}, 32'(tx_wdata), 32'(wdata));
      checkOutput({name, "_gnt_id"}, 32'(gnt_id), 32'(id));
      if (!holdValid) req_valid = '0;
      tick();
      waitIdle(name);
   endtask

   initial begin
      // 16'h73F8 holds samples -8,-1,3,7 for sources 0..3
      vecs[0] = '{4'b0001, 16'h73F5, 0, 4'h5};
      vecs[1] = '{4'b1010, 16'h73F8, 1, 4'hF};
      vecs[2] = '{4'b1010, 16'h73F8, 3, 4'h7};
      vecs[3] = '{4'b1010, 16'h73F8, 1, 4'hF};
      vecs[4] = '{4'b0100, 16'h73F8, 2, 4'h3};
      vecs[5] = '{4'b1111, 16'h73F8, 3, 4'h7};
      vecs[6] = '{4'b1111, 16'h73F8, 0, 4'h8};
      vecs[7] = '{4'b0011, 16'h73F8, 1, 4'hF};
      vecs[8] = '{4'b1001, 16'h73F8, 3, 4'h7};
      vecs[9] = '{4'b0001, 16'h73F8, 0, 4'h8};
      for (int i = 0; i < 4; i++) perSrc[i] = 0;

      applyReset();
      for (int i = 0; i < 10; i++) begin
         runGrant($sformatf("vec%0d", i), vecs[i].valid, vecs[i].data,
                  vecs[i].expId, vecs[i].expWdata, 0);
      end

      // all sources held valid: fair rotation
      applyReset();
      begin
         logic [3:0] seq[5];
         seq = '{4'h8, 4'hF, 4'h3, 4'h7, 4'h8};
         for (int i = 0; i < 5; i++) begin
            runGrant($sformatf("rot%0d", i), 4'b1111, 16'h73F8, i % 4, seq[i], i != 4);
         end
      end

      // sources 1 and 3 after last=1; source 3 withdraws mid-wait
      applyReset();
      runGrant("rr_a", 4'b0010, 16'h73F8, 1, 4'hF, 0);
      runGrant("rr_b", 4'b1010, 16'h73F8, 3, 4'h7, 1);
      runGrant("rr_c", 4'b1010, 16'h73F8, 1, 4'hF, 0);
      for (int c = 0; c < 10; c++) begin
         tick();
         checkOutput("rr_dropped_no_ready", 32'(req_ready), 32'd0);
      end

      // sdm_tx not empty in IDLE blocks the grant
      applyReset();
      forceFull = 1;
      tx_empty  = 1'b0;
      applyStimulus(4'b0001, 16'h73F8);
      for (int c = 0; c < 5; c++) begin
         tick();
         checkOutput("blk_no_ready", 32'(req_ready), 32'd0);
         checkOutput("blk_busy", 32'(busy), 32'd0);
      end
      forceFull = 0;
      tx_empty  = 1'b1;
      tick();
      checkOutput("blk_release_ready", 32'(req_ready), 32'd1);
      tick();
      checkOutput("blk_release_push", 32'(tx_push), 32'd1);
      req_valid = '0;
      waitIdle("blk");

      // reset asserted mid-frame
      applyReset();
      applyStimulus(4'b0100, 16'h73F8);
      waitReady();
      checkOutput("midrst_ready", 32'(req_ready), 32'b0100);
      tick();
      checkOutput("midrst_gnt_id", 32'(gnt_id), 32'd2);
      req_valid = '0;
      repeat (5) tick();
      checkOutput("midrst_busy", 32'(busy), 32'd1);
      #3;
      applyReset();
      applyStimulus(4'b1111, 16'h73F8);
      waitReady();
      checkOutput("midrst_first_grant", 32'(req_ready), 32'd1);
      req_valid = '0;
      tick();
      tick();
      waitIdle("midrst");

      // randomized traffic against the round-robin model
      applyReset();
      mLast       = 3;
      pushDue     = 0;
      outstanding = 0;
      stall       = 0;
      grants      = 0;
      randFrame   = 1;
      scoreOn     = 1;
      repeat (1500) tick();
      scoreOn   = 0;
      randFrame = 0;
      checkOutput("rnd_grants_seen", 32'(grants > 30), 32'd1);
      for (int i = 0; i < 4; i++) begin
         checkOutput($sformatf("rnd_src%0d_served", i), 32'(perSrc[i] > 0), 32'd1);
      end

      // sdm_tx stuck non-empty after a push
      applyReset();
      applyStimulus(4'b0001, 16'h73F8);
      waitReady();
      tick();
      checkOutput("stuck_push", 32'(tx_push), 32'd1);
      req_valid = '0;
      forceFull = 1;
`ifdef SDM_SCHED_TMO_EN
      for (int c = 1; c <= 16; c++) begin
         tick();
         if (c == 15) checkOutput("tmo_no_clear_early", 32'(tx_clear), 32'd0);
      end
      checkOutput("tmo_clear", 32'(tx_clear), 32'd1);
      checkOutput("tmo_err_not_yet", 32'(err), 32'd0);
      tick();
      checkOutput("tmo_err_set", 32'(err), 32'd1);
      checkOutput("tmo_clear_1cyc", 32'(tx_clear), 32'd0);
      checkOutput("tmo_back_idle", 32'(busy), 32'd0);
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
      checkOutput("tmo_err_cleared", 32'(err), 32'd0);
`else
      err_clr = 1'b1;
      for (int c = 0; c < 40; c++) begin
         tick();
         checkOutput("stuck_no_clear", 32'(tx_clear), 32'd0);
      end
      err_clr = 1'b0;
      checkOutput("stuck_no_err", 32'(err), 32'd0);
      checkOutput("stuck_still_busy", 32'(busy), 32'd1);
`endif
      forceFull = 0;
      applyReset();

      $display("[TB] %0d tests run, %0d failed", testCount, failCount);
      $finish;
   end

   initial begin
      #500000;
      failCount++;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $display("[TB] %0d tests run, %0d failed", testCount, failCount);
      $finish;
   end

endmodule
